// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory arbiter with locked bursts; DMEM_ARB_ROUND_ROBIN_EN selects round-robin IDLE arbitration
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_lock,
  input  logic                  p1_lock,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  core_stall,
  output logic [1:0]            owner,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d, cnt_inc;
  logic                  last_gnt_q, last_gnt_d;
  logic                  p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic                  pick1, g0, g1, gnt, lock, keep;
  // grant decision, memory steering and next-state computation; grants are gated by reset
  always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    pick1 = ~last_gnt_q;
`else
    pick1 = 1'b0;
`endif
    g0 = rst & ((state_q == IDLE) ? p0_req & (~p1_req | ~pick1) : (state_q == OWN0) & p0_req);
    g1 = rst & ((state_q == IDLE) ? p1_req & (~p0_req | pick1) : (state_q == OWN1) & p1_req);
    gnt = g0 | g1;
    lock = g1 ? p1_lock : p0_lock;
    cnt_inc = (state_q == IDLE) ? CW'(1) : burst_cnt_q + CW'(1);
    keep = gnt & lock & (cnt_inc < CW'(MAX_BURST));
    state_d = keep ? (g1 ? OWN1 : OWN0) : IDLE;
    burst_cnt_d = keep ? cnt_inc : '0;
    last_gnt_d = gnt ? g1 : last_gnt_q;
    mem_we = gnt & (g1 ? p1_we : p0_we);
    mem_addr = g1 ? p1_addr : p0_addr;
    mem_wdata = g1 ? p1_wdata : p0_wdata;
    p0_rvalid_d = g0 & ~p0_we;
    p1_rvalid_d = g1 & ~p1_we;
    p0_rdata_d = p0_rvalid_d ? mem_rdata : p0_rdata_q;
    p1_rdata_d = p1_rvalid_d ? mem_rdata : p1_rdata_q;
  end
  // ownership FSM, burst counter, round-robin history and registered read return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_gnt_q  <= 1'b1;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end
  assign p0_gnt     = g0;
  assign p1_gnt     = g1;
  assign core_stall = p0_req & ~g0;
  assign owner      = state_q;
  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  assign p0_rdata   = p0_rdata_q;
  assign p1_rdata   = p1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus randomized traffic against a behavioural arbiter model
module tb_dmem_arbiter;
  localparam int MB = 4;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    bit          rst;
    bit [1:0]    req, lock, we;
    logic [7:0]  a0, a1;
    logic [31:0] d0, d1;
    bit          chk;
    bit          eg0, eg1, est;
    bit [1:0]    eown;
    bit          erv0, erv1;
    bit          chk_rd;
    logic [31:0] erd0;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0, lock = '0, we = '0;
  logic [7:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        g0, g1, rv0, rv1, stall, mem_we;
  logic [31:0] rd0, rd1, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic [7:0]  mem_addr;
  logic [31:0] mem [256];
  logic [31:0] mmem [256];
  int          m_own, m_cnt, m_last;
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  int          n_cmp = 0, n_bad = 0;
  vec_t        tv [$];
  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p1_req(req[1]), .p0_lock(lock[0]), .p1_lock(lock[1]),
    .p0_we(we[0]), .p1_we(we[1]), .p0_addr(a0), .p1_addr(a1),
    .p0_wdata(d0), .p1_wdata(d1), .p0_gnt(g0), .p1_gnt(g1),
    .p0_rvalid(rv0), .p1_rvalid(rv1), .p0_rdata(rd0), .p1_rdata(rd1),
    .core_stall(stall), .owner(owner), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(bit r, bit [1:0] rq, bit [1:0] lk, bit [1:0] w, logic [7:0] x0, logic [7:0] x1,
                              logic [31:0] y0, logic [31:0] y1, bit e0, bit e1, bit es, bit [1:0] eo, bit v0, bit v1);
    vec_t v;
    v = '{default: '0};
    v.rst = r; v.req = rq; v.lock = lk; v.we = w; v.a0 = x0; v.a1 = x1; v.d0 = y0; v.d1 = y1;
    v.chk = 1'b1; v.eg0 = e0; v.eg1 = e1; v.est = es; v.eown = eo; v.erv0 = v0; v.erv1 = v1;
    return v;
  endfunction
  task automatic step(vec_t v, int idx);
    int          win, n;
    logic [7:0]  ad [2];
    logic [31:0] wd [2];
    rst = v.rst; req = v.req; lock = v.lock; we = v.we;
    a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1;
    ad[0] = v.a0; ad[1] = v.a1; wd[0] = v.d0; wd[1] = v.d1;
    @(negedge clk);
    if (!v.rst) begin
      m_own = -1; m_cnt = 0; m_last = 1;
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    end
    chk($sformatf("owner@%0d", idx), {30'd0, owner}, m_own < 0 ? 0 : (m_own == 0 ? 1 : 2));
    chk($sformatf("p0_rvalid@%0d", idx), {31'd0, rv0}, {31'd0, m_rv[0]});
    chk($sformatf("p1_rvalid@%0d", idx), {31'd0, rv1}, {31'd0, m_rv[1]});
    chk($sformatf("p0_rdata@%0d", idx), rd0, m_rd[0]);
    chk($sformatf("p1_rdata@%0d", idx), rd1, m_rd[1]);
    if (!v.rst) win = -1;
    else if (m_own >= 0) win = v.req[m_own] ? m_own : -1;
    else if (v.req == 2'b11) win = RR ? 1 - m_last : 0;
    else win = v.req[0] ? 0 : (v.req[1] ? 1 : -1);
    chk($sformatf("p0_gnt@%0d", idx), {31'd0, g0}, {31'd0, win == 0});
    chk($sformatf("p1_gnt@%0d", idx), {31'd0, g1}, {31'd0, win == 1});
    chk($sformatf("core_stall@%0d", idx), {31'd0, stall}, {31'd0, v.req[0] && win != 0});
    chk($sformatf("mem_we@%0d", idx), {31'd0, mem_we}, {31'd0, win >= 0 && v.we[win]});
    chk($sformatf("mem_addr@%0d", idx), {24'd0, mem_addr}, {24'd0, win == 1 ? ad[1] : ad[0]});
    chk($sformatf("mem_wdata@%0d", idx), mem_wdata, win == 1 ? wd[1] : wd[0]);
    if (v.chk) begin
      chk($sformatf("tv_p0_gnt@%0d", idx), {31'd0, g0}, {31'd0, v.eg0});
      chk($sformatf("tv_p1_gnt@%0d", idx), {31'd0, g1}, {31'd0, v.eg1});
      chk($sformatf("tv_stall@%0d", idx), {31'd0, stall}, {31'd0, v.est});
      chk($sformatf("tv_owner@%0d", idx), {30'd0, owner}, {30'd0, v.eown});
      chk($sformatf("tv_p0_rvalid@%0d", idx), {31'd0, rv0}, {31'd0, v.erv0});
      chk($sformatf("tv_p1_rvalid@%0d", idx), {31'd0, rv1}, {31'd0, v.erv1});
      if (v.chk_rd) chk($sformatf("tv_p0_rdata@%0d", idx), rd0, v.erd0);
    end
    m_rv[0] = 0; m_rv[1] = 0;
    if (win >= 0) begin
      if (v.we[win]) mmem[ad[win]] = wd[win];
      else begin m_rv[win] = 1; m_rd[win] = mmem[ad[win]]; end
      n = (m_own == win) ? m_cnt + 1 : 1;
      m_last = win;
      if (v.lock[win] && n < MB) begin m_own = win; m_cnt = n; end
      else begin m_own = -1; m_cnt = 0; end
    end else begin
      m_own = -1; m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; mmem[i] = '0; end
    m_own = -1; m_cnt = 0; m_last = 1;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    tv.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 0, 0, 1, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    if (RR) begin
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 0, 1, 1, 2'b00, 1, 0));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 1, 0, 0, 2'b00, 0, 1));
    end else begin
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 1, 0, 0, 2'b00, 1, 0));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 0, 0, 1, 0, 0, 2'b00, 1, 0));
    end
    tv.push_back(mk(1, 2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 0, 1, 0, 0, 2'b00, 1, 0));
    tv.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    v = mk(1, 2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    v.chk_rd = 1'b1; v.erd0 = 32'hDEADBEEF;
    tv.push_back(v);
    tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b10, 2'b10, 2'b10, 8'h03, 8'h20, 0, 32'h11, 0, 1, 0, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b10, 8'h03, 8'h21, 0, 32'h22, 0, 1, 1, 2'b10, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b10, 8'h03, 8'h22, 0, 32'h33, 0, 1, 1, 2'b10, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b10, 8'h03, 8'h23, 0, 32'h44, 0, 1, 1, 2'b10, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b10, 8'h03, 8'h24, 0, 32'h55, 1, 0, 0, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b10, 2'b10, 2'b10, 8'h03, 8'h24, 0, 32'h55, 0, 1, 0, 2'b00, 1, 0));
    tv.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 0, 0, 0, 0, 1, 2'b10, 0, 0));
    tv.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b10, 2'b10, 2'b00, 8'h03, 8'h20, 0, 0, 0, 1, 0, 2'b00, 1, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b00, 8'h03, 8'h21, 0, 0, 0, 1, 1, 2'b10, 0, 1));
    tv.push_back(mk(0, 2'b11, 2'b10, 2'b00, 8'h03, 8'h21, 0, 0, 0, 0, 1, 2'b00, 0, 0));
    tv.push_back(mk(1, 2'b11, 2'b10, 2'b00, 8'h03, 8'h21, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    foreach (tv[i]) step(tv[i], i);
    for (int i = 0; i < 3000; i++) begin
      v = '{default: '0};
      v.rst = ($urandom_range(99) != 0);
      v.req = 2'($urandom_range(3));
      v.lock = {$urandom_range(3) != 0, $urandom_range(3) != 0};
      v.we = 2'($urandom_range(3));
      v.a0 = 8'($urandom_range(15));
      v.a1 = 8'($urandom_range(15));
      v.d0 = $urandom;
      v.d1 = $urandom;
      step(v, 1000 + i);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
